// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory controller between the instruction-fetch (I) and
// data (D) ports: one transaction at a time, round-robin on ties, with a watchdog.
module mem_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 16,
  parameter int TO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic [DWIDTH-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int              WD_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);
  localparam logic [DWIDTH-1:0] ABORT_DATA = DWIDTH'(32'hDEAD_BEEF);

  logic [2:0]        state_q,      state_d;
  logic              owner_q,      owner_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_valid_q,  mem_valid_d;
  logic              mem_rw_q,     mem_rw_d;
  logic [AWIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [DWIDTH-1:0] mem_wdata_q,  mem_wdata_d;
  logic              i_done_q,     i_done_d;
  logic              d_done_q,     d_done_d;
  logic [DWIDTH-1:0] i_rdata_q,    i_rdata_d;
  logic [DWIDTH-1:0] d_rdata_q,    d_rdata_d;
  logic              timeout_q,    timeout_d;
  logic [WD_W-1:0]   wd_q,         wd_d;
  logic              pick_d;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_valid_d  = 1'b0;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    timeout_d    = timeout_q;
    wd_d         = wd_q;
    pick_d       = GRANT_I;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          // D wins when alone, or on a tie when I held the last grant.
          pick_d      = d_req && (!i_req || (last_grant_q == GRANT_I));
          owner_d     = pick_d;
          mem_rw_d    = (pick_d == GRANT_D) ? d_rw    : 1'b1;
          mem_addr_d  = (pick_d == GRANT_D) ? d_addr  : i_addr;
          mem_wdata_d = (pick_d == GRANT_D) ? d_wdata : '0;
          mem_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: state_d = S_GAP;

      // The controller only drops Ready the cycle after Valid, so Ready is ignored here.
      S_GAP: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem_ready) begin
          if (mem_rw_q) begin
            if (owner_q == GRANT_D) d_rdata_d = mem_rdata;
            else                    i_rdata_d = mem_rdata;
          end
          i_done_d = (owner_q == GRANT_I);
          d_done_d = (owner_q == GRANT_D);
          state_d  = S_DONE;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          if (mem_rw_q) begin
            if (owner_q == GRANT_D) d_rdata_d = ABORT_DATA;
            else                    i_rdata_d = ABORT_DATA;
          end
          i_done_d = (owner_q == GRANT_I);
          d_done_d = (owner_q == GRANT_D);
          state_d  = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_DONE: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= GRANT_I;
      last_grant_q <= GRANT_I;
      mem_valid_q  <= 1'b0;
      mem_rw_q     <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      timeout_q    <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_valid_q  <= mem_valid_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      timeout_q    <= timeout_d;
      wd_q         <= wd_d;
    end
  end

  assign mem_valid   = mem_valid_q;
  assign mem_rw      = mem_rw_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign i_done      = i_done_q;
  assign d_done      = d_done_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small controller model plus hand-computed expectations.
module tb_mem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int TO  = 64;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_rw;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          i_done, d_done;
  logic          mem_valid, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b1;
  logic          timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  // 0 = Ready drops after Valid and returns LAT cycles later, 1 = always high, 2 = stuck low
  int ctrl_mode = 0;
  int ctrl_cnt  = 0;

  // results of the last wait_done call
  bit            wd_owner_d;
  logic [DW-1:0] wd_rdata;
  int            wd_nvalid, wd_delay, wd_stab, wd_overlap;
  logic          wd_rw;
  logic [AW-1:0] wd_addr;
  logic [DW-1:0] wd_wdata;

  mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      mem_ready = 1'b1;
      ctrl_cnt  = 0;
    end else begin
      case (ctrl_mode)
        0: begin
          if (mem_valid) begin
            mem_ready = 1'b0;
            ctrl_cnt  = LAT;
          end else if (ctrl_cnt > 1) begin
            ctrl_cnt = ctrl_cnt - 1;
          end else if (ctrl_cnt == 1) begin
            ctrl_cnt  = 0;
            mem_ready = 1'b1;
            mem_rdata = 32'hA500_0000 | {16'h0000, mem_addr};
          end else begin
            mem_ready = 1'b1;
          end
        end
        1: begin
          mem_ready = 1'b1;
          if (mem_valid) mem_rdata = 32'hA500_0000 | {16'h0000, mem_addr};
        end
        default: begin
          mem_ready = 1'b0;
          mem_rdata = 32'h0BAD_0BAD;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_mem_valid"}, mem_valid, 1'b0);
    check({pfx, "_mem_rw"}, mem_rw, 1'b1);
    check({pfx, "_mem_addr"}, mem_addr, '0);
    check({pfx, "_mem_wdata"}, mem_wdata, '0);
    check({pfx, "_dones"}, {i_done, d_done}, 2'b00);
    check({pfx, "_i_rdata"}, i_rdata, '0);
    check({pfx, "_d_rdata"}, d_rdata, '0);
    check({pfx, "_timeout"}, timeout_err, 1'b0);
  endtask

  // Waits (bounded) for the next done pulse, recording Valid count, latency from Valid,
  // stability of the mem_* bus after Valid and any simultaneous done pulses.
  task automatic wait_done();
    bit seen = 0;
    bit got  = 0;
    wd_nvalid = 0; wd_delay = 0; wd_stab = 0; wd_overlap = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (mem_valid) begin
        wd_nvalid++;
        seen     = 1;
        wd_delay = 0;
        wd_rw    = mem_rw;
        wd_addr  = mem_addr;
        wd_wdata = mem_wdata;
      end else if (seen) begin
        wd_delay++;
        if (mem_rw !== wd_rw || mem_addr !== wd_addr || mem_wdata !== wd_wdata) wd_stab++;
      end
      if (i_done && d_done) wd_overlap++;
      if (i_done || d_done) begin
        got        = 1;
        wd_owner_d = d_done;
        wd_rdata   = d_done ? d_rdata : i_rdata;
      end
    end
    if (!got) check("done_budget", 1'b0, 1'b1);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int hits = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (i_done || d_done || mem_valid) hits++;
    end
    check(tag, hits, 0);
  endtask

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_rw = 1; i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;

    // both requests held: D, I, D, I
    i_addr = 16'h0040; d_addr = 16'h0030; d_rw = 1; d_wdata = 32'hFFFF_0000;
    i_req = 1; d_req = 1;
    for (int t = 0; t < 4; t++) begin
      wait_done();
      check($sformatf("rr%0d_owner", t), wd_owner_d, (t % 2 == 0));
      check($sformatf("rr%0d_rdata", t), wd_rdata,
            (t % 2 == 0) ? 32'hA500_0030 : 32'hA500_0040);
      check($sformatf("rr%0d_overlap", t), wd_overlap, 0);
      check($sformatf("rr%0d_nvalid", t), wd_nvalid, 1);
    end
    i_req = 0; d_req = 0;
    check_quiet("rr_quiet", 3);

    // single I read
    i_addr = 16'h0010; i_req = 1;
    wait_done();
    i_req = 0;
    check("iread_owner", wd_owner_d, 1'b0);
    check("iread_rw", wd_rw, 1'b1);
    check("iread_addr", wd_addr, 16'h0010);
    check("iread_rdata", wd_rdata, 32'hA500_0010);
    check("iread_delay", wd_delay, 4);
    check("iread_nvalid", wd_nvalid, 1);
    check("iread_stable", wd_stab, 0);
    check_quiet("iread_quiet", 3);

    // D write: d_rdata keeps the value of the last D read
    d_rw = 0; d_addr = 16'h0020; d_wdata = 32'h1234_5678; d_req = 1;
    wait_done();
    d_req = 0;
    check("dwr_owner", wd_owner_d, 1'b1);
    check("dwr_rw", wd_rw, 1'b0);
    check("dwr_addr", wd_addr, 16'h0020);
    check("dwr_wdata", wd_wdata, 32'h1234_5678);
    check("dwr_stable", wd_stab, 0);
    check("dwr_rdata_kept", d_rdata, 32'hA500_0030);
    check("dwr_delay", wd_delay, 4);
    check_quiet("dwr_quiet", 3);

    // Ready never dropped: completes on the first WAIT cycle
    ctrl_mode = 1;
    i_addr = 16'h0070; i_req = 1;
    wait_done();
    i_req = 0;
    check("rdyhi_delay", wd_delay, 3);
    check("rdyhi_rdata", wd_rdata, 32'hA500_0070);
    check("rdyhi_nvalid", wd_nvalid, 1);
    check_quiet("rdyhi_quiet", 4);

    // Ready stuck low: watchdog abort
    ctrl_mode = 2;
    check("to_pre", timeout_err, 1'b0);
    d_rw = 1; d_addr = 16'h0080; d_req = 1;
    wait_done();
    d_req = 0;
    check("to_owner", wd_owner_d, 1'b1);
    check("to_delay", wd_delay, TO + 2);
    check("to_flag", timeout_err, 1'b1);
    check("to_rdata", wd_rdata, 32'hDEAD_BEEF);
    check_quiet("to_quiet", 2);
    check("to_sticky", timeout_err, 1'b1);

    // reset in the middle of WAIT
    d_addr = 16'h0050; d_req = 1;
    begin
      bit vseen = 0;
      for (int k = 0; k < 20 && !vseen; k++) begin
        @(negedge clk);
        if (mem_valid) vseen = 1;
      end
      check("rstw_valid_seen", vseen, 1'b1);
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("rstw");
    check_quiet("rstw_nodone", 3);
    d_req = 0; ctrl_mode = 0;
    rst = 1'b0;

    // served normally after reset
    i_addr = 16'h0060; i_req = 1;
    wait_done();
    i_req = 0;
    check("post_owner", wd_owner_d, 1'b0);
    check("post_rdata", wd_rdata, 32'hA500_0060);
    check("post_delay", wd_delay, 4);
    check("post_timeout", timeout_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
